fc3_io_ctrl: RTL and testbench

FC3_IO_CTRL -- requirements
Module: fc3_io_ctrl

---
 rtl/fc3_io_ctrl.sv | 146 ++++++++++++++
 tb/tb_fc3_io_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fc3_io_ctrl.sv
// fc3_io_ctrl: gathers a beat stream of activations into a parallel vector for
// the FC3 layer, waits a fixed settle time, then samples the layer's one-hot
// result and hands it downstream as an encoded class index.
module fc3_io_ctrl #(
    parameter int N_IN   = 32,
    parameter int W_IN   = 4,
    parameter int N_CLS  = 10,
    parameter int SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [W_IN-1:0]      s_data,
    input  logic                 s_last,
    output logic [N_IN*W_IN-1:0] act_out,
    input  logic [N_CLS-1:0]     res_onehot,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [3:0]           m_class,
    output logic                 m_tie,
    output logic                 len_err
);

    typedef enum logic [1:0] {ST_LOAD, ST_WAIT, ST_OUT} state_t;

    localparam logic [4:0] LAST_IDX = 5'(N_IN - 1);
    localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

    state_t                state_q, state_d;
    logic [4:0]            idx_q, idx_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [N_IN*W_IN-1:0]  act_q, act_d;
    logic                  s_ready_q, s_ready_d;
    logic                  m_valid_q, m_valid_d;
    logic [3:0]            m_class_q, m_class_d;
    logic                  m_tie_q, m_tie_d;
    logic                  len_err_q, len_err_d;

    logic [4:0]            hot_cnt;
    logic [3:0]            hot_idx;
    logic [3:0]            enc_class;
    logic                  enc_tie;

    // Encode the layer result: anything other than exactly one set bit is a tie.
    always_comb begin
        hot_cnt = '0;
        hot_idx = '0;
        for (int unsigned k = 0; k < N_CLS; k++) begin
            if (res_onehot[k]) begin
                hot_cnt = hot_cnt + 5'd1;
                hot_idx = 4'(k);
            end
        end
        enc_tie   = (hot_cnt != 5'd1);
        enc_class = enc_tie ? 4'hF : hot_idx;
    end

    // Next-state and next-output logic for the LOAD/WAIT/OUT sequence.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        act_d     = act_q;
        s_ready_d = s_ready_q;
        m_valid_d = m_valid_q;
        m_class_d = m_class_q;
        m_tie_d   = m_tie_q;
        len_err_d = len_err_q;
        unique case (state_q)
            ST_LOAD: begin
                if (s_valid && s_ready_q) begin
                    // Write the current entry; an early s_last also clears the tail.
                    for (int unsigned i = 0; i < N_IN; i++) begin
                        if (5'(i) == idx_q)
                            act_d[i*W_IN +: W_IN] = s_data;
                        else if (s_last && (5'(i) > idx_q))
                            act_d[i*W_IN +: W_IN] = '0;
                    end
                    if (s_last || (idx_q == LAST_IDX)) begin
                        state_d   = ST_WAIT;
                        idx_d     = '0;
                        cnt_d     = '0;
                        s_ready_d = 1'b0;
                        len_err_d = !(s_last && (idx_q == LAST_IDX));
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d   = ST_OUT;
                    cnt_d     = '0;
                    m_valid_d = 1'b1;
                    m_class_d = enc_class;
                    m_tie_d   = enc_tie;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_OUT: begin
                if (m_ready) begin
                    state_d   = ST_LOAD;
                    idx_d     = '0;
                    m_valid_d = 1'b0;
                    s_ready_d = 1'b1;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    // State and registered outputs; asynchronous reset discards any work in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_LOAD;
            idx_q     <= '0;
            cnt_q     <= '0;
            act_q     <= '0;
            s_ready_q <= 1'b1;
            m_valid_q <= 1'b0;
            m_class_q <= 4'hF;
            m_tie_q   <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            act_q     <= act_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
            m_class_q <= m_class_d;
            m_tie_q   <= m_tie_d;
            len_err_q <= len_err_d;
        end
    end

    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign m_class = m_class_q;
    assign m_tie   = m_tie_q;
    assign len_err = len_err_q;
    assign act_out = act_q;

endmodule

// File: tb/tb_fc3_io_ctrl.sv
// Scoreboard bench for fc3_io_ctrl: the driver pushes the expected result when
// the final beat of a vector is presented, the monitor pops it on the handshake.
module tb_fc3_io_ctrl;

    localparam int SETTLE = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_valid;
    logic         s_ready;
    logic [3:0]   s_data;
    logic         s_last;
    logic [127:0] act_out;
    logic [9:0]   res_onehot;
    logic         m_valid;
    logic         m_ready;
    logic [3:0]   m_class;
    logic         m_tie;
    logic         len_err;

    fc3_io_ctrl #(.N_IN(32), .W_IN(4), .N_CLS(10), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .act_out(act_out), .res_onehot(res_onehot),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_class(m_class), .m_tie(m_tie), .len_err(len_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   cls;
        logic         tie;
        logic         le;
        logic [127:0] act;
        int           cyc;
    } exp_t;

    exp_t       exp_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    logic [3:0] vec[32];
    bit         chk_period = 0;

    // Cycle counter: value k after the k-th rising edge.
    always @(posedge clk) cyc++;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: latency on m_valid rise, result contents on the handshake.
    bit mv_prev   = 0;
    bit have_prev = 0;
    int last_rise = 0;
    always @(negedge clk) begin
        if (rst) begin
            mv_prev = 0;
        end else begin
            if (m_valid && !mv_prev) begin
                if (exp_q.size() == 0) check_val("unexpected_valid", 1, 0);
                else check_val("latency", 128'(cyc), 128'(exp_q[0].cyc));
                if (chk_period) begin
                    if (have_prev) check_val("period", 128'(cyc - last_rise), 128'd35);
                    have_prev = 1;
                end else begin
                    have_prev = 0;
                end
                last_rise = cyc;
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_result", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_val("m_class", 128'(m_class), 128'(e.cls));
                    check_val("m_tie", 128'(m_tie), 128'(e.tie));
                    check_val("len_err", 128'(len_err), 128'(e.le));
                    check_val("act_out", act_out, e.act);
                end
            end
            mv_prev = m_valid;
        end
    end

    // Present nb beats from vec; beats offered while s_ready=0 carry junk that must be ignored.
    task automatic send_vec(input int nb, input bit set_last, input logic [9:0] res,
                            input logic [3:0] ecls, input logic etie, input bit keep_valid);
        int   i = 0;
        int   guard = 0;
        bit   acc;
        exp_t e;
        while (i < nb && guard < 300) begin
            s_valid = 1'b1;
            if (s_ready) begin
                s_data = vec[i];
                s_last = set_last && (i == nb - 1);
                if (i == nb - 1 && (set_last || nb == 32)) begin
                    res_onehot = res;
                    for (int j = 0; j < 32; j++) e.act[4*j +: 4] = (j < nb) ? vec[j] : 4'h0;
                    e.cls = ecls;
                    e.tie = etie;
                    e.le  = !(set_last && nb == 32);
                    e.cyc = cyc + 1 + SETTLE;
                    exp_q.push_back(e);
                end else begin
                    res_onehot = 10'($urandom);
                end
            end else begin
                s_data = 4'hA;
                s_last = 1'b1;
            end
            acc = s_ready;
            @(posedge clk); #1;
            if (acc) i++;
            guard++;
        end
        if (guard >= 300) check_val("send_timeout", 0, 1);
        s_valid = keep_valid;
        s_data  = 4'hA;
        s_last  = 1'b1;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 100) check_val("drain_timeout", 0, 1);
    endtask

    task automatic wait_valid();
        int guard = 0;
        while (!m_valid && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) check_val("valid_timeout", 0, 1);
    endtask

    task automatic pulse_rst();
        #1 rst = 1'b1;
        #1;
        check_val("rst_act", act_out, '0);
        check_val("rst_s_ready", 128'(s_ready), 1);
        check_val("rst_m_valid", 128'(m_valid), 0);
        check_val("rst_m_class", 128'(m_class), 128'hF);
        check_val("rst_m_tie", 128'(m_tie), 0);
        check_val("rst_len_err", 128'(len_err), 0);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    logic [127:0] hold_act;

    initial begin
        rst = 1'b1; s_valid = 0; s_data = 0; s_last = 0; res_onehot = 0; m_ready = 1;
        #2;
        check_val("reset_s_ready", 128'(s_ready), 1);
        check_val("reset_m_valid", 128'(m_valid), 0);
        check_val("reset_m_class", 128'(m_class), 128'hF);
        check_val("reset_m_tie", 128'(m_tie), 0);
        check_val("reset_len_err", 128'(len_err), 0);
        check_val("reset_act", act_out, '0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        // Full vector, values cycling 0..15, class 3.
        for (int j = 0; j < 32; j++) vec[j] = 4'(j % 16);
        send_vec(32, 1, 10'b0000001000, 4'd3, 1'b0, 0);
        wait_idle();
        check_val("act_entry17", 128'(act_out[71:68]), 128'h1);

        // Early s_last at idx 5: tail cleared, len_err set.
        for (int j = 0; j < 32; j++) vec[j] = 4'h7;
        send_vec(6, 1, 10'b1000000000, 4'd9, 1'b0, 0);
        wait_idle();

        // 32 beats without s_last: len_err set.
        for (int j = 0; j < 32; j++) vec[j] = 4'($urandom);
        send_vec(32, 0, 10'b0000000001, 4'd0, 1'b0, 0);
        wait_idle();

        // No bit set, then two bits set: both are ties.
        send_vec(32, 1, 10'b0000000000, 4'hF, 1'b1, 0);
        wait_idle();
        send_vec(32, 1, 10'b1000000001, 4'hF, 1'b1, 0);
        wait_idle();

        // Hold in OUT while downstream stalls and inputs churn.
        m_ready = 1'b0;
        for (int j = 0; j < 32; j++) vec[j] = 4'($urandom);
        for (int j = 0; j < 32; j++) hold_act[4*j +: 4] = vec[j];
        send_vec(32, 1, 10'b0000100000, 4'd5, 1'b0, 0);
        wait_valid();
        for (int n = 0; n < 20; n++) begin
            s_valid = 1'b1; s_data = 4'h5; s_last = 1'b1; res_onehot = 10'($urandom);
            @(posedge clk); #1;
            check_val("hold_m_valid", 128'(m_valid), 1);
            check_val("hold_s_ready", 128'(s_ready), 0);
            check_val("hold_class", 128'(m_class), 128'd5);
            check_val("hold_tie_len", {m_tie, len_err}, 0);
            check_val("hold_act", act_out, hold_act);
        end
        m_ready = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0;
        check_val("release_m_valid", 128'(m_valid), 0);
        check_val("release_s_ready", 128'(s_ready), 1);
        check_val("release_drained", 128'(exp_q.size()), 0);

        // Reset after 12 accepted beats, then a full vector.
        for (int j = 0; j < 32; j++) vec[j] = 4'($urandom) | 4'h1;
        send_vec(12, 0, 10'b0, 4'h0, 1'b0, 0);
        pulse_rst();
        for (int j = 0; j < 32; j++) vec[j] = 4'($urandom);
        send_vec(32, 1, 10'b0001000000, 4'd6, 1'b0, 0);
        wait_idle();

        // Reset while a result is pending in OUT: the result vanishes.
        m_ready = 1'b0;
        send_vec(32, 1, 10'b0000000100, 4'd2, 1'b0, 0);
        wait_valid();
        void'(exp_q.pop_front());
        pulse_rst();
        m_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1 check_val("post_rst_no_valid", 128'(m_valid), 0);

        // Back-to-back with s_valid held high: one result every 35 cycles.
        chk_period = 1;
        for (int v = 0; v < 3; v++) begin
            for (int j = 0; j < 32; j++) vec[j] = 4'($urandom);
            send_vec(32, 1, 10'(1 << (v + 1)), 4'(v + 1), 1'b0, v < 2);
        end
        wait_idle();
        chk_period = 0;
        check_val("final_drained", 128'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
